// File: rtl/status_board_writer.sv
// status_board_writer: write-back stage of the board datapath.
// It takes one move (idx_a, idx_b, sum) over a valid/ready handshake and
// validates it. A valid move updates the N-slot 4-bit board and the
// score/move counters. This block is the only writer of the board.
// Build option: define STATUS_REFILL_EN to refill consumed slots from a
// 16-bit Galois LFSR. Without it, consumed slots are left empty (0).
module status_board_writer #(
  parameter int          N    = 10,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [3:0]     idx_a,
  input  logic [3:0]     idx_b,
  input  logic [3:0]     sum,
  output logic [N*4-1:0] status,
  output logic [7:0]     score,
  output logic [7:0]     moves,
  output logic           done,
  output logic           err,
  output logic           board_clear
);

  // state      | meaning
  // S_IDLE     | ready for a move; req_ready high
  // S_CHECK    | validate latched indices, sum and slot occupancy
  // S_WRITE    | slot b <= sum, bump counters (slot a cleared without refill)
  // S_REFILL_A | slot a <= LFSR-derived value 1..9
  // S_REFILL_B | slot b <= LFSR-derived value 1..9 (only after a sum of 0)
  // S_ERR      | one-cycle err pulse, board untouched
  // S_DONE     | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WRITE, S_REFILL_A, S_REFILL_B, S_ERR, S_DONE
  } state_t;

  localparam logic [3:0] N_IDX = 4'(N);

  // Slot i starts at (i mod 9)+1, so the reset board has no empty slots.
  function automatic logic [N*4-1:0] reset_board();
    logic [N*4-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) begin
      b[i*4 +: 4] = 4'((i % 9) + 1);
    end
    return b;
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     a_q, a_d;
  logic [3:0]     b_q, b_d;
  logic [3:0]     sum_q, sum_d;
  logic [N*4-1:0] status_q, status_d;
  logic [7:0]     score_q, score_d;
  logic [7:0]     moves_q, moves_d;
  logic [3:0]     slot_a, slot_b;

`ifdef STATUS_REFILL_EN
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  refill_val;

  // Galois LFSR for x^16+x^14+x^13+x^11+1, free-running every cycle.
  always_comb begin
    lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    refill_val = (lfsr_q[3:0] % 4'd9) + 4'd1;
  end

  // LFSR register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end
`else
  logic unused_seed;
  assign unused_seed = ^SEED;
`endif

  // Registers: FSM state, latched move, board and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      status_q <= reset_board();
      score_q  <= '0;
      moves_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      status_q <= status_d;
      score_q  <= score_d;
      moves_q  <= moves_d;
    end
  end

  // Next-state, move latch and board/counter updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    status_d = status_q;
    score_d  = score_q;
    moves_d  = moves_q;
    slot_a   = '0;
    slot_b   = '0;
    for (int i = 0; i < N; i++) begin
      if (a_q == 4'(i)) slot_a = status_q[i*4 +: 4];
      if (b_q == 4'(i)) slot_b = status_q[i*4 +: 4];
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = idx_a;
          b_d     = idx_b;
          sum_d   = sum;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Index bounds are tested first; slot_a/slot_b read 0 when out of range.
        if (a_q >= N_IDX || b_q >= N_IDX || a_q == b_q || sum_q > 4'd9 ||
            slot_a == 4'd0 || slot_b == 4'd0)
          state_d = S_ERR;
        else
          state_d = S_WRITE;
      end
      S_WRITE: begin
        for (int i = 0; i < N; i++) begin
          if (b_q == 4'(i)) status_d[i*4 +: 4] = sum_q;
`ifndef STATUS_REFILL_EN
          if (a_q == 4'(i)) status_d[i*4 +: 4] = 4'd0;
`endif
        end
        moves_d = moves_q + 8'd1;
        if (sum_q == 4'd0 && score_q != 8'hFF) score_d = score_q + 8'd1;
`ifdef STATUS_REFILL_EN
        state_d = S_REFILL_A;
`else
        state_d = S_DONE;
`endif
      end
`ifdef STATUS_REFILL_EN
      S_REFILL_A: begin
        for (int i = 0; i < N; i++) begin
          if (a_q == 4'(i)) status_d[i*4 +: 4] = refill_val;
        end
        state_d = (sum_q == 4'd0) ? S_REFILL_B : S_DONE;
      end
      S_REFILL_B: begin
        for (int i = 0; i < N; i++) begin
          if (b_q == 4'(i)) status_d[i*4 +: 4] = refill_val;
        end
        state_d = S_DONE;
      end
`endif
      S_ERR:   state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    done        = (state_q == S_DONE);
    err         = (state_q == S_ERR);
    status      = status_q;
    score       = score_q;
    moves       = moves_q;
    board_clear = (status_q == '0);
  end

endmodule

// File: tb/tb_status_board_writer.sv
// Testbench for status_board_writer (N=10). A move-level model predicts
// the board, counters and handshake pulses. A negedge process compares
// every output against that model. Directed moves add literal expectations.
module tb_status_board_writer;

  localparam int N = 10;

`ifdef STATUS_REFILL_EN
  localparam int LAT_NZ = 4;
  localparam int LAT_Z  = 5;
`else
  localparam int LAT_NZ = 3;
  localparam int LAT_Z  = 3;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_valid;
  logic           req_ready;
  logic [3:0]     idx_a, idx_b, sum;
  logic [N*4-1:0] status;
  logic [7:0]     score, moves;
  logic           done, err, board_clear;

  int n_pass  = 0;
  int n_total = 0;

  status_board_writer #(.N(N), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .idx_a(idx_a), .idx_b(idx_b), .sum(sum), .status(status),
    .score(score), .moves(moves), .done(done), .err(err),
    .board_clear(board_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int  m_status[N];
  int  m_score, m_moves;
  bit  busy;
  bit  lvalid;
  int  j, end_j;
  int  la, lb, ls;
`ifdef STATUS_REFILL_EN
  logic [15:0] m_lfsr;
  logic [15:0] old_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int refill_of(input logic [15:0] l);
    return int'(l[3:0]) % 9 + 1;
  endfunction
`endif

  // Windows after the accept edge are numbered j=1,2,...; end_j is the pulse window.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_status[i] = (i % 9) + 1;
      m_score = 0;
      m_moves = 0;
      busy    = 0;
      j       = 0;
`ifdef STATUS_REFILL_EN
      m_lfsr  = 16'hACE1;
`endif
    end else begin
`ifdef STATUS_REFILL_EN
      old_lfsr = m_lfsr;
      m_lfsr   = lfsr_step(m_lfsr);
`endif
      if (!busy) begin
        if (req_valid) begin
          la = int'(idx_a);
          lb = int'(idx_b);
          ls = int'(sum);
          lvalid = (la < N) && (lb < N) && (la != lb) && (ls <= 9) &&
                   (m_status[la] != 0) && (m_status[lb] != 0);
          end_j = !lvalid ? 2 : (ls == 0 ? LAT_Z : LAT_NZ);
          busy  = 1;
          j     = 1;
        end
      end else begin
        j++;
        if (lvalid) begin
          if (j == 3) begin
            m_status[lb] = ls;
            m_moves = (m_moves + 1) % 256;
            if (ls == 0 && m_score < 255) m_score++;
`ifndef STATUS_REFILL_EN
            m_status[la] = 0;
`endif
          end
`ifdef STATUS_REFILL_EN
          if (j == 4) m_status[la] = refill_of(old_lfsr);
          if (j == 5 && ls == 0) m_status[lb] = refill_of(old_lfsr);
`endif
        end
        if (j > end_j) busy = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    logic [N*4-1:0] exp_vec;
    bit all_zero;
    exp_vec  = '0;
    all_zero = 1;
    for (int i = 0; i < N; i++) begin
      exp_vec[i*4 +: 4] = 4'(m_status[i]);
      if (m_status[i] != 0) all_zero = 0;
    end
    check("status", 64'(status), 64'(exp_vec));
    check("score", 64'(score), 64'(m_score));
    check("moves", 64'(moves), 64'(m_moves));
    check("req_ready", 64'(req_ready), 64'(!busy));
    check("done", 64'(done), 64'(busy && lvalid && j == end_j));
    check("err", 64'(err), 64'(busy && !lvalid && j == end_j));
    check("board_clear", 64'(board_clear), 64'(all_zero));
  end

  // ---------------- stimulus ----------------
  task automatic do_move(input int a, input int b, input int s,
                         input bit exp_err, input int exp_lat);
    int  jj;
    bit  got_done, got_err;
    @(posedge clk); #1;
    req_valid = 1'b1;
    idx_a = 4'(a);
    idx_b = 4'(b);
    sum   = 4'(s);
    @(posedge clk); #1;
    req_valid = 1'b0;
    jj = 1;
    got_done = 0;
    got_err  = 0;
    while (jj <= 20 && !got_done && !got_err) begin
      @(negedge clk);
      if (done) got_done = 1;
      else if (err) got_err = 1;
      else jj++;
    end
    check("move_kind", 64'({got_done, got_err}), exp_err ? 64'h1 : 64'h2);
    check("move_latency", 64'(jj), 64'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0;
    idx_a = '0;
    idx_b = '0;
    sum   = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_status", 64'(status), 64'h1987654321);
    check("rst_score", 64'(score), 64'h0);
    check("rst_moves", 64'(moves), 64'h0);
    check("rst_ready", 64'(req_ready), 64'h1);
    check("rst_done_err", 64'({done, err}), 64'h0);

    // slot0 (1) + slot2 (3) = 4
    do_move(0, 2, 4, 0, LAT_NZ);
    check("m1_slot2", 64'(status[2*4 +: 4]), 64'h4);
    check("m1_moves", 64'(moves), 64'h1);
    check("m1_score", 64'(score), 64'h0);
`ifdef STATUS_REFILL_EN
    check("m1_slot0_range", 64'(status[0 +: 4] >= 4'd1 && status[0 +: 4] <= 4'd9), 64'h1);
`else
    check("m1_board", 64'(status), 64'h1987654420);
`endif

    // slot3 (4) + slot5 (6) = 10 -> sum 0
    do_move(3, 5, 0, 0, LAT_Z);
    check("m2_score", 64'(score), 64'h1);
    check("m2_moves", 64'(moves), 64'h2);
`ifdef STATUS_REFILL_EN
    check("m2_slot3_range", 64'(status[3*4 +: 4] >= 4'd1 && status[3*4 +: 4] <= 4'd9), 64'h1);
    check("m2_slot5_range", 64'(status[5*4 +: 4] >= 4'd1 && status[5*4 +: 4] <= 4'd9), 64'h1);
`else
    check("m2_board", 64'(status), 64'h1987050420);
`endif

    // rejected moves: same slot, index out of range, sum > 9, index == N
    do_move(4, 4, 5, 1, 2);
    do_move(4, 12, 5, 1, 2);
    do_move(4, 6, 10, 1, 2);
    do_move(10, 1, 3, 1, 2);
`ifndef STATUS_REFILL_EN
    do_move(0, 1, 2, 1, 2);
    check("err_board", 64'(status), 64'h1987050420);
`endif
    check("err_score", 64'(score), 64'h1);
    check("err_moves", 64'(moves), 64'h2);

    // sum = 9 is the largest legal value
    do_move(1, 6, 9, 0, LAT_NZ);
    check("m3_slot6", 64'(status[6*4 +: 4]), 64'h9);
    check("m3_moves", 64'(moves), 64'h3);

    // reset in the third window after accept (REFILL_A when refill is built in)
    @(posedge clk); #1;
    req_valid = 1'b1;
    idx_a = 4'd7;
    idx_b = 4'd8;
    sum   = 4'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_status", 64'(status), 64'h1987654321);
    check("mid_rst_counts", 64'({score, moves}), 64'h0);
    check("mid_rst_ready", 64'(req_ready), 64'h1);
    check("mid_rst_done_err", 64'({done, err}), 64'h0);

`ifndef STATUS_REFILL_EN
    // clear the board with five scoring moves
    do_move(0, 8, 0, 0, 3);
    do_move(1, 7, 0, 0, 3);
    do_move(2, 6, 0, 0, 3);
    do_move(3, 5, 0, 0, 3);
    do_move(9, 4, 0, 0, 3);
    @(negedge clk);
    check("end_board_clear", 64'(board_clear), 64'h1);
    check("end_status", 64'(status), 64'h0);
    check("end_score", 64'(score), 64'h5);
    check("end_moves", 64'(moves), 64'h5);
`else
    do_move(0, 8, 0, 0, LAT_Z);
    do_move(1, 7, 5, 0, LAT_NZ);
    check("end_score", 64'(score), 64'h1);
    check("end_moves", 64'(moves), 64'h2);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
